// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one up-counter to two requesters for timed runs.
// Every output is registered and shows the action of the state the FSM has just left.
module counter_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] len0_i,
  input  logic [WIDTH-1:0] len1_i,
  input  logic             tick_i,
  output logic [1:0]       gnt_o,
  output logic [WIDTH-1:0] count_o,
  output logic [1:0]       done_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lenSel_q, lenSel_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             winner_q, winner_d;
  logic             winnerReq;
  logic [1:0]       winnerOneHot;

  assign winnerReq    = req_i[winner_q];
  assign winnerOneHot = winner_q ? 2'b10 : 2'b01;

  // last resets to 1 so requester 0 takes the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      count_q  <= '0;
      lenSel_q <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      last_q   <= 1'b1;
      winner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      count_q  <= count_d;
      lenSel_q <= lenSel_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (|req_i) state_d = LOAD;
      LOAD:  state_d = winnerReq ? COUNT : IDLE;
      COUNT: begin
        if (!winnerReq) begin
          state_d = IDLE;
        end else if (tick_i && (count_q == lenSel_q)) begin
          state_d = DONE;
        end
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An abort wins over counting; count saturates at lenSel instead of wrapping
  always_comb begin
    gnt_d    = gnt_q;
    count_d  = count_q;
    lenSel_d = lenSel_q;
    done_d   = '0;
    busy_d   = (state_q != IDLE);
    last_d   = last_q;
    winner_d = winner_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req_i) begin
          winner_d = (req_i == 2'b11) ? ~last_q : req_i[1];
        end
      end
      LOAD: begin
        last_d   = winner_q;
        lenSel_d = winner_q ? len1_i : len0_i;
        if (winnerReq) begin
          gnt_d   = winnerOneHot;
          count_d = '0;
        end else begin
          gnt_d = '0;
        end
      end
      COUNT: begin
        if (!winnerReq) begin
          gnt_d = '0;
        end else if (tick_i && (count_q != lenSel_q)) begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: done_d = winnerOneHot;
      default: ;
    endcase
  end

  assign gnt_o   = gnt_q;
  assign count_o = count_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;

endmodule
